// File: rtl/uart_baud_pkg.sv
// Shared rate codes, default oversampling ratio and the divisor rounding
// function used by the oversampling UART baud generator.
package uart_baud_pkg;

  localparam logic [2:0] BAUD_2400   = 3'd0;
  localparam logic [2:0] BAUD_4800   = 3'd1;
  localparam logic [2:0] BAUD_9600   = 3'd2;
  localparam logic [2:0] BAUD_19200  = 3'd3;
  localparam logic [2:0] BAUD_38400  = 3'd4;
  localparam logic [2:0] BAUD_57600  = 3'd5;
  localparam logic [2:0] BAUD_115200 = 3'd6;
  localparam logic [2:0] BAUD_CUSTOM = 3'd7;

  localparam int OVERSAMPLE_DEF = 16;

  // Rounded clk_hz / (baud * os).
  function automatic int unsigned div_for(input int unsigned clk_hz,
                                          input int unsigned baud,
                                          input int unsigned os);
    return (clk_hz + (baud * os) / 2) / (baud * os);
  endfunction

endpackage

// File: rtl/baud_tick_cnt.sv
// Enabled modulo-N counter with a registered one-cycle pulse in the cycle
// after it wraps; modulus 0 parks the counter at 0.
module baud_tick_cnt #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] modulus,
  output logic [W-1:0] count,
  output logic         tick
);

  logic wrap;

  // >= rather than == so a modulus that shrinks below the count still wraps.
  assign wrap = inc && (modulus != '0) && (count >= modulus - W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clr || (modulus == '0)) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= wrap;
      if (inc) count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/baud_gen_os.sv
// Oversampling UART baud generator: rx_tick at OVERSAMPLE x baud, tx_tick at baud.
// Define BAUD_CLK_EN to add a 50% duty baud_clk output; otherwise it is tied low.
module baud_gen_os
  import uart_baud_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int DIV_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [2:0]       baud_sel,
  input  logic [DIV_W-1:0] custom_div,
  output logic             rx_tick,
  output logic             tx_tick,
  output logic             rate_upd,
  output logic             baud_clk
);

  localparam int OS_W = $clog2(OVERSAMPLE) + 1;
  localparam logic [OS_W-1:0]  OS_MOD  = OS_W'(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(div_for(CLK_FREQ_HZ, 2400, OVERSAMPLE));

  logic [DIV_W-1:0] sel_div;
  logic [DIV_W-1:0] act_div;
  logic [DIV_W-1:0] rx_cnt;
  logic [OS_W-1:0]  os_cnt;
  logic             first_ld;
  logic             load;
  logic             run;
  logic             rx_wrap_nxt;

  always_comb begin
    sel_div = custom_div;
    case (baud_sel)
      BAUD_2400:   sel_div = DIV_W'(div_for(CLK_FREQ_HZ, 2400,   OVERSAMPLE));
      BAUD_4800:   sel_div = DIV_W'(div_for(CLK_FREQ_HZ, 4800,   OVERSAMPLE));
      BAUD_9600:   sel_div = DIV_W'(div_for(CLK_FREQ_HZ, 9600,   OVERSAMPLE));
      BAUD_19200:  sel_div = DIV_W'(div_for(CLK_FREQ_HZ, 19200,  OVERSAMPLE));
      BAUD_38400:  sel_div = DIV_W'(div_for(CLK_FREQ_HZ, 38400,  OVERSAMPLE));
      BAUD_57600:  sel_div = DIV_W'(div_for(CLK_FREQ_HZ, 57600,  OVERSAMPLE));
      BAUD_115200: sel_div = DIV_W'(div_for(CLK_FREQ_HZ, 115200, OVERSAMPLE));
      default:     sel_div = custom_div;
    endcase
  end

  // A halted generator keeps sampling the selection so it can recover.
  assign run         = enable && (act_div != '0);
  assign load        = !enable || (act_div == '0) || tx_tick;
  assign rx_wrap_nxt = run && (rx_cnt >= act_div - DIV_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_div  <= DIV_RST;
      first_ld <= 1'b1;
      rate_upd <= 1'b0;
    end else begin
      rate_upd <= load && (first_ld || (sel_div != act_div));
      if (load) begin
        act_div  <= sel_div;
        first_ld <= 1'b0;
      end
    end
  end

  baud_tick_cnt #(.W(DIV_W)) u_rx_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (!run),
    .inc     (1'b1),
    .modulus (act_div),
    .count   (rx_cnt),
    .tick    (rx_tick)
  );

  // Advancing on the pre-registered rx wrap lines tx_tick up with rx_tick.
  baud_tick_cnt #(.W(OS_W)) u_os_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (!run),
    .inc     (rx_wrap_nxt),
    .modulus (OS_MOD),
    .count   (os_cnt),
    .tick    (tx_tick)
  );

`ifdef BAUD_CLK_EN
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);

  logic baud_q;
  logic toggle;

  assign toggle = rx_wrap_nxt && ((os_cnt == OS_MOD - OS_W'(1)) || (os_cnt == OS_HALF));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     baud_q <= 1'b0;
    else if (!run)    baud_q <= 1'b0;
    else if (toggle)  baud_q <= ~baud_q;
  end

  assign baud_clk = baud_q;
`else
  logic os_cnt_unused;
  assign os_cnt_unused = ^os_cnt;
  assign baud_clk      = 1'b0;
`endif

endmodule

// File: tb/tb_baud_gen_os.sv
// Directed self-checking bench for baud_gen_os at default parameters.
module tb_baud_gen_os;
  import uart_baud_pkg::*;

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b0;
  logic        enable     = 1'b0;
  logic [2:0]  baud_sel   = BAUD_9600;
  logic [15:0] custom_div = 16'd0;
  logic        rx_tick, tx_tick, rate_upd, baud_clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int at     = 0;
  int hits   = 0;

  always #5 clock = ~clock;

  baud_gen_os dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .baud_sel   (baud_sel),
    .custom_div (custom_div),
    .rx_tick    (rx_tick),
    .tx_tick    (tx_tick),
    .rate_upd   (rate_upd),
    .baud_clk   (baud_clk)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return rx_tick;
      1:       return tx_tick;
      2:       return rate_upd;
      3:       return baud_clk;
      default: return rx_tick | tx_tick;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  // Returns the cycle at which the signal reaches lvl, or -1 if the bound expires.
  task automatic wait_lvl(input int which, input logic lvl, input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      cyc++;
      if (sig(which) === lvl) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic count_hi(input int which, input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cyc++;
      if (sig(which) === 1'b1) h++;
    end
  endtask

  initial begin
    // Reset state
    step(2);
    check("rst_rx_tick", rx_tick, 0);
    check("rst_tx_tick", tx_tick, 0);
    check("rst_rate_upd", rate_upd, 0);
    check("rst_baud_clk", baud_clk, 0);

    // First load after reset pulses rate_upd once
    reset_n = 1'b1;
    step(1);
    check("rate_upd_first", rate_upd, 1);
    step(1);
    check("rate_upd_once", rate_upd, 0);

    // 9600 baud, then switch to 115200 mid-bit
    enable = 1'b1;
    cyc = 0;
    wait_lvl(0, 1'b1, 1000, at);  check("rx_first_9600", at, 326);
    wait_lvl(0, 1'b1, 1000, at);  check("rx_second_9600", at, 652);
    step(1000 - cyc);
    baud_sel = BAUD_115200;
    wait_lvl(0, 1'b1, 1000, at);  check("rx_after_sel_chg", at, 1304);
    wait_lvl(1, 1'b1, 6000, at);  check("tx_first_9600", at, 5216);
    check("tx_on_rx", rx_tick, 1);
    wait_lvl(2, 1'b1, 10, at);    check("rate_upd_boundary", at, 5217);
    wait_lvl(0, 1'b1, 1000, at);  check("rx_first_115200", at, 5243);
    wait_lvl(1, 1'b1, 1000, at);  check("tx_next_115200", at, 5648);

    // Enable dropped mid-bit and raised again
    enable   = 1'b0;
    baud_sel = BAUD_9600;
    step(3);
    enable = 1'b1;
    cyc = 0;
    step(3000);
    enable = 1'b0;
    step(1);
    check("dis_rx_low", rx_tick, 0);
    check("dis_tx_low", tx_tick, 0);
    count_hi(4, 999, hits);       check("dis_no_ticks", hits, 0);
    enable = 1'b1;
    wait_lvl(0, 1'b1, 1000, at);  check("reen_rx_first", at, 4326);
    wait_lvl(0, 1'b1, 1000, at);  check("reen_rx_period", at, 4652);

    // Custom divisor 0 halts, 10 recovers
    enable     = 1'b0;
    baud_sel   = BAUD_CUSTOM;
    custom_div = 16'd0;
    step(2);
    enable = 1'b1;
    count_hi(4, 300, hits);       check("halt_no_ticks", hits, 0);
    custom_div = 16'd10;
    cyc = 0;
    wait_lvl(2, 1'b1, 10, at);    check("custom_rate_upd", at, 1);
    wait_lvl(0, 1'b1, 100, at);   check("custom_rx_first", at, 11);
    wait_lvl(0, 1'b1, 100, at);   check("custom_rx_period", at, 21);
    wait_lvl(1, 1'b1, 400, at);   check("custom_tx_first", at, 161);
    wait_lvl(1, 1'b1, 400, at);   check("custom_tx_period", at, 321);

    // Square wave at 115200
    enable   = 1'b0;
    baud_sel = BAUD_115200;
    step(2);
    enable = 1'b1;
    cyc = 0;
`ifdef BAUD_CLK_EN
    wait_lvl(3, 1'b1, 1000, at);  check("baud_clk_rise", at, 216);
    check("baud_clk_rise_on_rx", rx_tick, 1);
    wait_lvl(3, 1'b0, 1000, at);  check("baud_clk_fall", at, 432);
    check("baud_clk_fall_on_tx", tx_tick, 1);
    wait_lvl(3, 1'b1, 1000, at);  check("baud_clk_rise2", at, 648);
`else
    count_hi(3, 700, hits);       check("baud_clk_tied_low", hits, 0);
`endif

    // Divisor 1: rx_tick held high, tx every 16 cycles
    enable     = 1'b0;
    baud_sel   = BAUD_CUSTOM;
    custom_div = 16'd1;
    step(2);
    enable = 1'b1;
    cyc = 0;
    count_hi(0, 32, hits);        check("div1_rx_high", hits, 32);
    count_hi(1, 32, hits);        check("div1_tx_count", hits, 2);

    // Asynchronous reset while rx_tick and tx_tick are high
    reset_n = 1'b0;
    #1;
    check("async_rst_rx", rx_tick, 0);
    check("async_rst_tx", tx_tick, 0);
    check("async_rst_rate_upd", rate_upd, 0);
    check("async_rst_baud_clk", baud_clk, 0);
    baud_sel = BAUD_9600;
    step(2);
    reset_n = 1'b1;
    cyc = 0;
    wait_lvl(0, 1'b1, 2000, at);  check("post_rst_rx_first", at, 1302);
    wait_lvl(0, 1'b1, 2000, at);  check("post_rst_rx_period", at, 2604);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
